// File: rtl/challenge_gen.sv
// Challenge source for the XOR-PUF datapath: issues an LFSR sequence of num
// challenges over a valid/ready handshake and reports count/busy/done.
module challenge_gen #(
   parameter int                  CHAL_W = 8,
   parameter int                  CNT_W  = 16,
   parameter logic [CHAL_W-1:0]   POLY   = 8'hB8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CHAL_W-1:0] seed,
   input  logic [CNT_W-1:0]  num,
   input  logic              ready,
   output logic [CHAL_W-1:0] chal,
   output logic              valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  count
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_reg, state_next;
   logic [CHAL_W-1:0]   chal_reg, chal_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic [CNT_W-1:0]    num_reg, num_next;
   logic                done_reg, done_next;

   logic                handshake;
   logic                last;
   logic [CNT_W-1:0]    count_inc;
   logic [CHAL_W-1:0]   lfsr_step;

   assign count_inc = count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
   assign last      = (count_inc == num_reg);
   assign handshake = (state_reg == RUN) && ready;
   // Galois step: shift right, fold the feedback mask in when a one falls out
   assign lfsr_step = (chal_reg >> 1) ^ (chal_reg[0] ? POLY : {CHAL_W{1'b0}});

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         chal_reg  <= '0;
         count_reg <= '0;
         num_reg   <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         chal_reg  <= chal_next;
         count_reg <= count_next;
         num_reg   <= num_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start && (num != '0)) state_next = RUN;
         RUN:  if (handshake && last)    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath / registered-output next values
   always_comb begin
      chal_next  = chal_reg;
      count_next = count_reg;
      num_next   = num_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               count_next = '0;
               if (num == '0) begin
                  done_next = 1'b1;
               end else begin
                  num_next  = num;
                  // all-zero is the LFSR lock-up state, so substitute 1
                  chal_next = (seed == '0) ? {{(CHAL_W-1){1'b0}}, 1'b1} : seed;
               end
            end
         end
         RUN: begin
            if (handshake) begin
               count_next = count_inc;
               if (last) done_next = 1'b1;
               else      chal_next = lfsr_step;
            end
         end
         default: ;
      endcase
   end

   assign chal  = chal_reg;
   assign valid = (state_reg == RUN);
   assign busy  = (state_reg == RUN);
   assign done  = done_reg;
   assign count = count_reg;

endmodule

// File: tb/tb_challenge_gen.sv
// Directed bench for challenge_gen: expected challenges are queued when a run
// is started and popped at each observed handshake.
module tb_challenge_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  seed;
   logic [15:0] num;
   logic        ready;
   logic [7:0]  chal;
   logic        valid;
   logic        busy;
   logic        done;
   logic [15:0] count;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   int          cnt_exp;
   logic [7:0]  last_obs;

   challenge_gen dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .seed  (seed),
      .num   (num),
      .ready (ready),
      .chal  (chal),
      .valid (valid),
      .busy  (busy),
      .done  (done),
      .count (count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model_step(input logic [7:0] s);
      logic [7:0] r;
      r = s >> 1;
      if (s[0]) r = r ^ 8'hB8;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic do_start(input logic [7:0] s, input logic [15:0] n);
      logic [7:0] m;
      start = 1'b1; seed = s; num = n;
      m = (s == 8'h00) ? 8'h01 : s;
      exp_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         exp_q.push_back(m);
         m = model_step(m);
      end
      cnt_exp = 0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check("start_valid", {31'd0, valid}, {31'd0, n != 16'd0});
      check("start_busy",  {31'd0, busy},  {31'd0, n != 16'd0});
      check("start_count", {16'd0, count}, 32'd0);
   endtask

   task automatic do_cycle(input logic r);
      logic       hs;
      logic [7:0] prev;
      logic [7:0] e;
      ready = r;
      hs    = valid && r;
      prev  = chal;
      check("count_track", {16'd0, count}, cnt_exp);
      if (hs) begin
         if (exp_q.size() == 0) begin
            check("unexpected_hs", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("chal", {24'd0, chal}, {24'd0, e});
            last_obs = chal;
            $display("handshake chal=%h count=%0d", chal, cnt_exp + 1);
         end
      end
      @(posedge clk); @(negedge clk);
      if (hs) cnt_exp++;
      else if (valid) check("stall_hold", {24'd0, chal}, {24'd0, prev});
   endtask

   task automatic drain(input logic [6:0] pat, input int plen);
      int k = 0;
      while (exp_q.size() != 0 && k < 2000) begin
         do_cycle(pat[k % plen]);
         k++;
      end
      if (k >= 2000) check("drain_timeout", 32'd1, 32'd0);
   endtask

   task automatic check_done(input logic [15:0] n);
      check("done_pulse",  {31'd0, done},  32'd1);
      check("done_valid",  {31'd0, valid}, 32'd0);
      check("done_busy",   {31'd0, busy},  32'd0);
      check("done_count",  {16'd0, count}, {16'd0, n});
      ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("done_clear",  {31'd0, done},  32'd0);
      check("count_hold",  {16'd0, count}, {16'd0, n});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; seed = '0; num = '0; ready = 1'b0;
      cnt_exp = 0; last_obs = '0;
      repeat (2) @(negedge clk);
      check("rst_chal",  {24'd0, chal},  32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_done",  {31'd0, done},  32'd0);
      check("rst_count", {16'd0, count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Continuous ready
      do_start(8'h6E, 16'd4);
      check("first_chal", {24'd0, chal}, 32'h6E);
      drain(7'b1111111, 7);
      check_done(16'd4);

      // ready toggling 1,0,0,1,0,1,1
      do_start(8'h6E, 16'd4);
      drain(7'b1101001, 7);
      check_done(16'd4);

      // Zero seed is replaced by 1
      do_start(8'h00, 16'd2);
      check("zero_seed", {24'd0, chal}, 32'h01);
      drain(7'b1111111, 7);
      check_done(16'd2);

      // Full period plus one wraps back to the seed
      do_start(8'h01, 16'd256);
      drain(7'b1111111, 7);
      check("wrap_chal", {24'd0, last_obs}, 32'h01);
      check_done(16'd256);

      // num = 0
      do_start(8'h55, 16'd0);
      check("num0_done", {31'd0, done}, 32'd1);
      ready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("num0_done_clear", {31'd0, done},  32'd0);
      check("num0_valid",      {31'd0, valid}, 32'd0);
      check("num0_count",      {16'd0, count}, 32'd0);

      // Reset mid-run
      do_start(8'h6E, 16'd10);
      do_cycle(1'b1);
      do_cycle(1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_chal",  {24'd0, chal},  32'd0);
      check("mid_rst_valid", {31'd0, valid}, 32'd0);
      check("mid_rst_busy",  {31'd0, busy},  32'd0);
      check("mid_rst_count", {16'd0, count}, 32'd0);
      @(posedge clk); @(negedge clk);
      check("mid_rst_done",  {31'd0, done},  32'd0);
      rst = 1'b0;
      do_start(8'h6E, 16'd1);
      drain(7'b1111111, 7);
      check_done(16'd1);

      // start during RUN is ignored
      do_start(8'h6E, 16'd4);
      do_cycle(1'b1);
      start = 1'b1; seed = 8'h11; num = 16'd2;
      do_cycle(1'b1);
      start = 1'b0;
      drain(7'b1111111, 7);
      check_done(16'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
